// File: rtl/fetch_if.sv
// Fetch-stage bus: PC/branch inputs, program-load port, and decode-facing outputs.
interface fetch_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic [PC_W-1:0]    PC;
  logic               taken;
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output PC, taken, load_en, load_addr, load_data,
    input  instr, instr_valid, done, cycle_count, instr_count
  );

  modport slave (
    input  PC, taken, load_en, load_addr, load_data,
    output instr, instr_valid, done, cycle_count, instr_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program memory, one-cycle registered fetch,
// wrong-path squash on taken branch, sticky halt and saturating counters.
module fetch_stage #(
  parameter int                 PC_W       = 7,
  parameter int                 INSTR_W    = 9,
  parameter int                 CNT_W      = 16,
  parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
  input  logic clk,
  input  logic reset,
  fetch_if.slave bus
);
  localparam int DEPTH = 2 ** PC_W;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             r_state, w_state_nxt;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_done;
  logic [CNT_W-1:0]   r_cyc;
  logic [CNT_W-1:0]   r_icnt;
  logic               w_halt_hit;
  logic [CNT_W-1:0]   w_cyc_inc;
  logic [CNT_W-1:0]   w_icnt_inc;

  assign w_halt_hit = (r_state == S_RUN) && r_valid && (r_instr == HALT_INSTR);
  assign w_cyc_inc  = (&r_cyc)  ? r_cyc  : r_cyc  + CNT_W'(1);
  assign w_icnt_inc = (&r_icnt) ? r_icnt : r_icnt + CNT_W'(1);

  // Program memory write; unaffected by reset or halt so loads always land.
  always_ff @(posedge clk) begin
    if (bus.load_en) r_mem[bus.load_addr] <= bus.load_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state: a valid halt word presented in RUN parks the stage in HALT.
  always_comb begin
    w_state_nxt = r_state;
    if (w_halt_hit) w_state_nxt = S_HALT;
  end

  // Fetch datapath and counters; everything freezes once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= '0;
      r_icnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc <= w_cyc_inc;
      if (r_valid) r_icnt <= w_icnt_inc;
      if (w_halt_hit) begin
        // Halt beats a same-cycle branch; instr keeps the halt word.
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        // Read-before-write falls out of the nonblocking memory update.
        r_instr <= r_mem[bus.PC];
        r_valid <= ~bus.taken;
      end
    end
  end

  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.done        = r_done;
  assign bus.cycle_count = r_cyc;
  assign bus.instr_count = r_icnt;
endmodule
